// File: rtl/rotator_pkg.sv
// Shared types and constants for the rotator arbiter slice.
// Optional feature macro: ROT_LEFT_EN (per-requester left-rotate direction).
package rotator_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [AMT_W-1:0]  amt_t;

  // IDLE: output register empty, HOLD: output register full
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // A left rotate by n equals a right rotate by (DATA_W - n) mod DATA_W
  function automatic amt_t left_to_right_amt(input amt_t amt);
    return amt_t'(0) - amt;
  endfunction

endpackage

// File: rtl/rotator_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the result consumer.
// Optional feature macro: ROT_LEFT_EN adds req0_left/req1_left.
interface rotator_arbiter_if import rotator_pkg::*; ();

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  data_t      req0_data;
  data_t      req1_data;
  amt_t       req0_amt;
  amt_t       req1_amt;
`ifdef ROT_LEFT_EN
  logic       req0_left;
  logic       req1_left;
`endif
  logic       out_valid;
  logic       out_ready;
  data_t      out_data;
  logic       out_id;

  // Requesters and consumer side
  modport master (
`ifdef ROT_LEFT_EN
    output req0_left, req1_left,
`endif
    output req_valid, req0_data, req1_data, req0_amt, req1_amt, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  // Arbiter side
  modport slave (
`ifdef ROT_LEFT_EN
    input  req0_left, req1_left,
`endif
    input  req_valid, req0_data, req1_data, req0_amt, req1_amt, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/right_rotator.sv
// Combinational 8-bit right rotator shared by both requesters.
module right_rotator import rotator_pkg::*; (
  input  data_t data_i,
  input  amt_t  amt_i,
  output data_t data_o
);

  // Select the rotated operand for the requested amount
  always_comb begin
    data_o = data_i;
    unique case (amt_i)
      3'd0: data_o = data_i;
      3'd1: data_o = {data_i[0],   data_i[7:1]};
      3'd2: data_o = {data_i[1:0], data_i[7:2]};
      3'd3: data_o = {data_i[2:0], data_i[7:3]};
      3'd4: data_o = {data_i[3:0], data_i[7:4]};
      3'd5: data_o = {data_i[4:0], data_i[7:5]};
      3'd6: data_o = {data_i[5:0], data_i[7:6]};
      3'd7: data_o = {data_i[6:0], data_i[7]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/rotator_arbiter.sv
// Two-requester arbiter in front of one shared right-rotate datapath with a
// single-entry output register (latency 1, one result per cycle sustained).
// Optional feature macro: ROT_LEFT_EN (per-requester left-rotate direction).
module rotator_arbiter import rotator_pkg::*; #(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  rotator_arbiter_if.slave  bus
);

  state_e     state_q;
  logic       ptr_q;
  logic       out_valid_q;
  data_t      out_data_q;
  logic       out_id_q;

  logic       can_accept;
  logic       sel;
  logic [1:0] grant;
  logic       accept;
  data_t      rot_in;
  amt_t       rot_amt;
  data_t      rot_out;

  // Grant selection: single requester wins outright, contention resolved by
  // the pointer (round-robin) or requester 0 (fixed priority); no grant in reset
  always_comb begin
    can_accept = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
    sel        = 1'b0;
    unique case (bus.req_valid)
      2'b10:   sel = 1'b1;
      2'b11:   sel = RR_EN ? ptr_q : 1'b0;
      default: sel = 1'b0;
    endcase
    grant = '0;
    if (can_accept && bus.req_valid[sel]) begin
      grant[sel] = 1'b1;
    end
    accept = |grant;
  end

  // Operand steering into the shared datapath
  always_comb begin
    rot_in  = sel ? bus.req1_data : bus.req0_data;
    rot_amt = sel ? bus.req1_amt  : bus.req0_amt;
`ifdef ROT_LEFT_EN
    if (sel ? bus.req1_left : bus.req0_left) begin
      rot_amt = left_to_right_amt(rot_amt);
    end
`endif
  end

  right_rotator u_rot (
    .data_i (rot_in),
    .amt_i  (rot_amt),
    .data_o (rot_out)
  );

  // Output-register FSM with registered result, id and priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      ptr_q       <= 1'b0;
    end else begin
      if (accept) begin
        out_data_q <= rot_out;
        out_id_q   <= sel;
        ptr_q      <= ~sel;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          // accept in HOLD implies out_ready, so the old result leaves as the new one lands
          if (!accept && bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: doc/rotator_arbiter.md
ROTATOR_ARBITER -- requirements
Module: rotator_arbiter

Interface
REQ-001 SHALL have parameter: RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 SHALL have port: req_ready  output  2  per-requester accept; transfer when req_valid[i] & req_ready[i].
REQ-006 SHALL have ports: req0_data, req1_data  input  8 each  operand to rotate.
REQ-007 SHALL have ports: req0_amt, req1_amt  input  3 each  right-rotate amount 0..7.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accept; transfer when out_valid & out_ready.
REQ-010 SHALL have port: out_data  output  8  rotated result.
REQ-011 SHALL have port: out_id  output  1  index of requester that produced out_data.

Function
REQ-012 SHALL share one 8-bit right-rotate datapath between two requesters; out_data = operand rotated right by amt (amt 0 -> unchanged, amt 7 -> {d[6:0],d[7]}).
REQ-013 SHALL implement states IDLE (output register empty) and HOLD (output register full).
REQ-014 SHALL define can_accept = (state==IDLE) | (state==HOLD & out_ready).
REQ-015 SHALL assert at most one req_ready bit per cycle, only when can_accept and the corresponding req_valid is set; req_ready SHALL depend combinationally on req_valid, state, out_ready and the priority pointer only.
REQ-016 SHALL, with one requester valid, grant that requester.
REQ-017 SHALL, with both valid and RR_EN=1, grant the requester not granted most recently; pointer updates only on an accepted transfer; pointer reset value favours requester 0.
REQ-018 SHALL, with both valid and RR_EN=0, always grant requester 0.
REQ-019 SHALL register the rotated result and granted index on accept; out_valid rises the cycle after accept (latency 1).
REQ-020 SHALL transition IDLE->HOLD on accept; HOLD->IDLE on output transfer with no new accept; HOLD->HOLD on output transfer with simultaneous accept (one result per cycle sustained).
REQ-021 SHALL keep out_data, out_id, out_valid stable while out_valid & !out_ready.
REQ-022 SHALL leave requester-side data unsampled when its req_ready is low; a non-granted valid request SHALL remain pending with no loss.

Reset
REQ-023 SHALL on rst_n low asynchronously force state=IDLE, out_valid=0, out_data=8'h00, out_id=0, priority pointer to requester 0; req_ready SHALL be 2'b00 while rst_n is low.
REQ-024 SHALL discard any held result on reset mid-operation; first accept after release proceeds normally.

Configuration
REQ-025 SHALL support macro ROT_LEFT_EN: when defined, add inputs req0_left, req1_left (1 bit each); a set bit rotates left by amt, implemented by driving the right-rotate datapath with (8-amt) mod 8.
REQ-026 SHALL, with ROT_LEFT_EN undefined, have no direction ports and perform right rotation only.

Structure
REQ-027 SHALL place state encoding (IDLE, HOLD), data width 8 and amount width 3 in shared package rotator_pkg.
REQ-028 SHALL instantiate the existing right_rotator as its one datapath sub-module; arbitration, state and output register reside in rotator_arbiter.

Verification
REQ-029 SHALL cover: req0 only, data 8'hB4 amt 3, out_ready=1 -> next cycle out_valid=1, out_data=8'h96, out_id=0.
REQ-030 SHALL cover: both valid every cycle, RR_EN=1, out_ready=1 -> out_id alternates 0,1,0,1 with one result per cycle.
REQ-031 SHALL cover: both valid, RR_EN=0 -> requester 0 always granted; req_ready[1] stays 0.
REQ-032 SHALL cover: out_ready=0 for 4 cycles while HOLD -> out_data/out_id constant, req_ready=2'b00; out_ready=1 -> transfer and same-cycle new accept.
REQ-033 SHALL cover: rst_n low during HOLD -> out_valid=0, out_data=8'h00 immediately, pointer back to requester 0.
REQ-034 SHALL cover (ROT_LEFT_EN): req1 data 8'h81 amt 1 left=1 -> out_data=8'h03, out_id=1; amt 0 -> data unchanged.
